// File: rtl/camera_pio_pkg.sv
// Shared constants for the camera status PIO input port: register word
// addresses and edge-type encodings used by the top and the edge detector.
package camera_pio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_TSTAMP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_MASK   = 2'd1,
    REG_EDGE   = 2'd2,
    REG_TSTAMP = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/pio_in_edge_detect.sv
// Per-bit synchroniser chain for the asynchronous status inputs, a flop
// holding the previous synchronised sample, and the rise/fall/any edge select.
module pio_in_edge_detect
  import camera_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] det_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  // Shift the raw inputs down the chain; the prev flop trails the last stage.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain and prev sample registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Select which transition of the synchronised value counts as an event.
  always_comb begin
    sync_o = sync_q[SYNC_STAGES-1];
    if (EDGE_TYPE == EDGE_FALL) begin
      det_o = ~sync_o & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      det_o = sync_o ^ prev_q;
    end else begin
      det_o = sync_o & ~prev_q;
    end
  end

endmodule

// File: rtl/camera_status_pio_in.sv
// Avalon-MM input port for camera status lines: DATA / MASK / sticky W1C EDGE
// registers, a warm-up guard after reset, and a registered maskable level irq.
// Optional macro CAMERA_STATUS_TSTAMP_EN adds a free-running cycle counter
// whose value is latched into TSTAMP when EDGE leaves the all-zero state.
module camera_status_pio_in
  import camera_pio_pkg::*;
#(
  parameter int               WIDTH          = 4,
  parameter int               SYNC_STAGES    = 2,
  parameter int               EDGE_TYPE      = EDGE_RISE,
  parameter logic [WIDTH-1:0] IRQ_RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Counter is 2 bits at the default depth and widens for deeper chains.
  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  sync_s, det_raw, det;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  edge_q, edge_d;
  logic [WIDTH-1:0]  clr;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       tstamp_val;
  logic              wr_en;
  logic              warm_done;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  pio_in_edge_detect #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge_detect (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .sync_o (sync_s),
    .det_o  (det_raw)
  );

`ifdef CAMERA_STATUS_TSTAMP_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tstamp_q, tstamp_d;

  // Free-running cycle counter; latch it when the first event lands in EDGE.
  always_comb begin
    cnt_d    = cnt_q + 32'd1;
    tstamp_d = tstamp_q;
    if ((edge_q == '0) && (edge_d != '0)) begin
      tstamp_d = cnt_q;
    end
  end

  // Timestamp state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tstamp_q <= tstamp_d;
    end
  end

  assign tstamp_val = tstamp_q;
`else
  assign tstamp_val = 32'd0;
`endif

  // Bus decode, warm-up gating, register updates, irq and read mux.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    warm_done = (warm_q == WARM_LAST);
    warm_d    = warm_done ? warm_q : warm_q + 1'b1;
    det       = warm_done ? det_raw : '0;

    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end

    clr = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      clr = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~clr) | det;

    irq_d = |(edge_q & mask_q);

    readdata_d = readdata_q;
    if (chipselect) begin
      readdata_d = '0;
      case (reg_sel_e'(address))
        REG_DATA:   readdata_d[WIDTH-1:0] = sync_s;
        REG_MASK:   readdata_d[WIDTH-1:0] = mask_q;
        REG_EDGE:   readdata_d[WIDTH-1:0] = edge_q;
        REG_TSTAMP: readdata_d            = tstamp_val;
        default:    readdata_d            = '0;
      endcase
    end
  end

  // Architectural registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q     <= IRQ_RESET_MASK;
      edge_q     <= '0;
      warm_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      warm_q     <= warm_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
